// File: rtl/simd_dispatch.sv
// Issues requests to a fixed-latency SIMD unit and returns the results with their tags, in order, through a DEPTH-entry FIFO.
// Results appear LAT+1 cycles after the issue strobe. A credit count covers the FIFO plus in-flight work, so req_rdy never over-commits the FIFO.
module simd_dispatch #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [12:0]   req_op,
  input  logic [67:0]   req_A,
  input  logic [67:0]   req_B,
  input  logic [TW-1:0] req_tag,
  input  logic          flush,
  output logic          simd_en,
  output logic [12:0]   simd_op,
  output logic [67:0]   simd_A,
  output logic [67:0]   simd_B,
  input  logic [67:0]   simd_res,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [67:0]   out_res,
  output logic [TW-1:0] out_tag,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] infl_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [67:0]   mem_res [DEPTH];
  logic [TW-1:0] mem_tag [DEPTH];
  logic [TW-1:0] iss_tag;
  logic [LAT-1:0] pipe_vld;
  logic [TW-1:0] pipe_tag [LAT];
  logic accept;
  logic cap;
  logic full;
  logic push;
  logic pop;

  // Credits span acceptance through pop, so a capture can never find the FIFO full.
  assign full    = (fifo_cnt == FULL);
  assign req_rdy = rst & (({1'b0, fifo_cnt} + {1'b0, infl_cnt}) < {1'b0, FULL});
  assign accept  = req_vld & req_rdy & ~flush;
  assign cap     = pipe_vld[LAT-1];
  assign push    = cap & ~full & ~flush;
  assign out_vld = (fifo_cnt != '0);
  assign pop     = out_vld & out_rdy & ~flush;
  assign out_res = mem_res[rd_ptr];
  assign out_tag = mem_tag[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      simd_en <= 1'b0;
      simd_op <= '0;
      simd_A  <= '0;
      simd_B  <= '0;
      iss_tag <= '0;
    end else begin
      simd_en <= accept;
      if (accept) begin
        simd_op <= req_op;
        simd_A  <= req_A;
        simd_B  <= req_B;
        iss_tag <= req_tag;
      end
    end
  end

  // Tag pipeline mirrors the execution unit's latency; it never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= simd_en & ~flush;
      pipe_tag[0] <= iss_tag;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1] & ~flush;
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_res[wr_ptr] <= simd_res;
        mem_tag[wr_ptr] <= pipe_tag[LAT-1];
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_cnt <= '0;
      err      <= 1'b0;
    end else begin
      infl_cnt <= flush ? '0 : (infl_cnt + CW'(accept) - CW'(cap));
      err      <= err | (cap & full & ~flush) | (out_rdy & ~out_vld);
    end
  end

endmodule

// File: tb/tb_simd_dispatch.sv
// Randomized scoreboard bench for simd_dispatch with a behavioural execution-unit model.
module tb_simd_dispatch;
  localparam int LAT = 2, DEPTH = 4, TW = 6;

  logic clk = 1'b0, rst = 1'b0;
  logic req_vld = 1'b0, req_rdy, flush = 1'b0;
  logic [12:0] req_op = '0;
  logic [67:0] req_A = '0, req_B = '0;
  logic [TW-1:0] req_tag = '0;
  logic simd_en;
  logic [12:0] simd_op;
  logic [67:0] simd_A, simd_B, simd_res = '0;
  logic out_vld, out_rdy, err;
  logic [67:0] out_res;
  logic [TW-1:0] out_tag;
  logic rdy_follow = 1'b0, rdy_bit = 1'b0, rdy_force = 1'b0;

  always #5 clk = ~clk;
  assign out_rdy = rdy_follow ? (out_vld & rdy_bit) : rdy_force;

  simd_dispatch #(.LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_A(req_A), .req_B(req_B), .req_tag(req_tag), .flush(flush),
    .simd_en(simd_en), .simd_op(simd_op), .simd_A(simd_A), .simd_B(simd_B),
    .simd_res(simd_res), .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .out_tag(out_tag), .err(err));

  typedef struct {logic [12:0] op; logic [67:0] a; logic [67:0] b; logic [TW-1:0] tag; logic [67:0] res;} txn_t;
  typedef struct {int due; logic [67:0] val;} ret_t;

  txn_t iss_q[$];
  txn_t exp_q[$];
  ret_t exec_q[$];
  int checks = 0, failures = 0, occ = 0, cyc = 0, n_acc = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=unexpected want=none", name);
  endtask

  // Reference execution unit: op-keyed mix of the operands.
  function automatic txn_t rand_txn(input logic [TW-1:0] tag);
    txn_t t;
    logic [95:0] ra, rb;
    ra = {$urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom};
    t.op  = 13'($urandom);
    t.a   = ra[67:0];
    t.b   = rb[67:0];
    t.tag = tag;
    t.res = ({55'b0, t.op} ^ t.a) + t.b;
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: checks issue outputs, plays the execution unit, scores popped results.
  txn_t mon_t;
  ret_t mon_r;
  always @(negedge clk) begin
    if (rst) begin
      if (simd_en) begin
        if (iss_q.size() == 0) fail_now("issue_unexpected");
        else begin
          mon_t = iss_q.pop_front();
          chk("simd_op", simd_op, mon_t.op);
          chk("simd_A", simd_A, mon_t.a);
          chk("simd_B", simd_B, mon_t.b);
          mon_r.due = cyc + LAT;
          mon_r.val = mon_t.res;
          exec_q.push_back(mon_r);
        end
      end
      if (out_vld && !flush) begin
        if (exp_q.size() == 0) fail_now("out_unexpected");
        else if (out_rdy) begin
          mon_t = exp_q.pop_front();
          chk("out_res", out_res, mon_t.res);
          chk("out_tag", out_tag, mon_t.tag);
          occ--;
        end
      end
      while (exec_q.size() > 0 && exec_q[0].due < cyc) void'(exec_q.pop_front());
      simd_res = {$urandom, $urandom, $urandom};
      if (exec_q.size() > 0 && exec_q[0].due == cyc) begin
        simd_res = exec_q[0].val;
        void'(exec_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; returns 1ns after the next rising edge.
  task automatic step(input logic v, input logic fl, input txn_t tx);
    req_vld = v;
    req_op  = tx.op;
    req_A   = tx.a;
    req_B   = tx.b;
    req_tag = tx.tag;
    flush   = fl;
    @(negedge clk);
    if (fl) begin
      exp_q.delete();
      occ = 0;
    end else if (v && req_rdy) begin
      iss_q.push_back(tx);
      exp_q.push_back(tx);
      occ++;
      n_acc++;
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    flush   = 1'b0;
    chk("req_rdy", req_rdy, 128'(occ < DEPTH));
    chk("err", err, err_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tx;
    int k, n0;
    #2;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_simd_en", simd_en, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_err", err, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_simd_op", simd_op, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", req_rdy, 1);

    // Single op, idle-FIFO latency.
    tx.op = 13'h040; tx.a = 68'h1; tx.b = 68'h2; tx.tag = 6'd5; tx.res = 68'hABC;
    step(1'b1, 1'b0, tx);
    chk("issue_strobe", simd_en, 1);
    k = 0;
    while (!out_vld && k < 20) begin
      step(1'b0, 1'b0, rand_txn(0));
      k++;
    end
    chk("result_latency", k, LAT + 1);
    chk("single_res", out_res, 68'hABC);
    chk("single_tag", out_tag, 5);
    rdy_follow = 1'b1; rdy_bit = 1'b1;
    repeat (3) step(1'b0, 1'b0, rand_txn(0));

    // Back-pressure: four accepts fill the credits.
    rdy_follow = 1'b0; rdy_force = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_txn(TW'(i)));
    chk("bp_full_rdy", req_rdy, 0);
    step(1'b1, 1'b0, rand_txn(9));
    repeat (LAT + 3) step(1'b0, 1'b0, rand_txn(0));
    chk("bp_head_tag", out_tag, 0);
    rdy_force = 1'b1;
    step(1'b0, 1'b0, rand_txn(0));
    rdy_force = 1'b0;
    chk("bp_rdy_after_pop", req_rdy, 1);
    rdy_follow = 1'b1; rdy_bit = 1'b1;
    repeat (6) step(1'b0, 1'b0, rand_txn(0));

    // Streaming with an always-ready consumer.
    n0 = n_acc;
    k = 0;
    while (n_acc - n0 < 20 && k < 60) begin
      step(1'b1, 1'b0, rand_txn(TW'(k)));
      k++;
    end
    chk("stream_accepts", n_acc - n0, 20);
    repeat (8) step(1'b0, 1'b0, rand_txn(0));

    // Flush with two ops in flight.
    step(1'b1, 1'b0, rand_txn(1));
    step(1'b1, 1'b0, rand_txn(2));
    step(1'b0, 1'b1, rand_txn(0));
    chk("flush_simd_en", simd_en, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, rand_txn(0));
      chk("flush_out_vld", out_vld, 0);
    end

    // Randomized traffic with occasional flushes and consumer stalls.
    for (int i = 0; i < 300; i++) begin
      rdy_bit = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0), rand_txn(TW'($urandom)));
    end
    rdy_bit = 1'b1;
    repeat (10) step(1'b0, 1'b0, rand_txn(0));
    chk("drain_empty", exp_q.size(), 0);

    // Asynchronous reset with three buffered results.
    rdy_follow = 1'b0; rdy_force = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_txn(TW'(i)));
    repeat (LAT + 3) step(1'b0, 1'b0, rand_txn(0));
    chk("pre_rst_out_vld", out_vld, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_req_rdy", req_rdy, 0);
    chk("arst_simd_en", simd_en, 0);
    iss_q.delete(); exp_q.delete(); exec_q.delete(); occ = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    rdy_follow = 1'b1; rdy_bit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, rand_txn(0));
      chk("post_rst_out_vld", out_vld, 0);
    end

    // Pop of an empty FIFO sets the sticky error.
    rdy_follow = 1'b0; rdy_force = 1'b1;
    err_exp = 1'b1;
    step(1'b0, 1'b0, rand_txn(0));
    rdy_force = 1'b0;
    repeat (4) step(1'b0, 1'b0, rand_txn(0));
    rst = 1'b0;
    #1;
    chk("err_cleared_by_rst", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
